sand_row_fetch: RTL and testbench
=================================

# sand_row_fetch

Frame-level sequencer for the falling-sand simulation. It walks the packed cell grid in grid RAM bottom-up, one 32-bit word (16 cells × 2 bits) at a time. For each word it reads the region word and the floor word directly below it, presents them to `sand_update` with the row-edge flags, and writes `new_region`/`new_floor` back to the same addresses. One full pass per `start` pulse advances the simulation by one step.

## Interface
- `WORDS_PER_ROW`, default 40: 32-bit words per grid row (640 cells).
- `ROWS`, default 480: grid rows; must be ≥ 2.
- `ADDR_W`, default 15: grid RAM word-address width; must satisfy ROWS·WORDS_PER_ROW ≤ 2^ADDR_W.
- `clk` in 1: single clock; all logic on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse that begins a pass; honoured only in IDLE.
- `busy` out 1: high from the cycle after an accepted `start` through the DONE cycle.
- `done` out 1: one-cycle pulse at pass completion.
- `mem_addr` out ADDR_W: grid RAM word address.
- `mem_re` out 1: read strobe. Data appears on `mem_rdata` the next cycle.
- `mem_we` out 1: write strobe.
- `mem_wdata` out 32: write data.
- `mem_rdata` in 32: read data, 1-cycle latency.
- `region` out 32: current word to `sand_update`.
- `floor` out 32: word below to `sand_update`.
- `docalculations` out 1: evaluate strobe to `sand_update`.
- `screenbegin` out 1: current word is column 0.
- `screenend` out 1: current word is column WORDS_PER_ROW-1.
- `new_region` in 32: `sand_update` result, combinational from `region`/`floor`.
- `new_floor` in 32: `sand_update` result, combinational from `region`/`floor`.

## Operation
- Word address = `row_base` + `col`, where `row_base` = row·WORDS_PER_ROW. `row_base` is maintained incrementally (subtract WORDS_PER_ROW per row); there is no multiplier. Floor address = region address + WORDS_PER_ROW.
- Scan order: row ROWS-2 down to 0; within a row, col 0 up to WORDS_PER_ROW-1. Row ROWS-1 is never a region row; it is touched only as a floor.
- FSM states and transitions:
  - IDLE: on `start`, load row=ROWS-2, col=0, `row_base`=(ROWS-2)·WORDS_PER_ROW, then go to RD_R.
  - RD_R: `mem_re`=1 at the region address, then go to RD_F.
  - RD_F: `mem_re`=1 at the floor address; latch `mem_rdata` into `region`; go to LATCH.
  - LATCH: latch `mem_rdata` into `floor`; go to CALC.
  - CALC: `docalculations`=1; capture `new_region`/`new_floor` into write registers at the edge; go to WR_R.
  - WR_R: `mem_we`=1 at the region address with captured `new_region`; go to WR_F.
  - WR_F: `mem_we`=1 at the floor address with captured `new_floor`; go to NEXT.
  - NEXT: if col<WORDS_PER_ROW-1, increment col. Otherwise set col=0. Then, if row=0, go to DONE. Otherwise decrement row and `row_base` and go to RD_R.
  - DONE: `done`=1; go to IDLE.
- `screenbegin`/`screenend` are decoded from `col` and are valid in every state from RD_R through NEXT. Both are high when WORDS_PER_ROW=1.
- `start` outside IDLE is ignored.
- `mem_re` and `mem_we` are never high in the same cycle. `mem_addr` is 0 when neither strobe is high.

## Timing
- Reset values: all outputs 0; state IDLE; row, col, `row_base`, `region`, `floor` and write registers all 0.
- Assertion of `reset_n` mid-pass aborts the pass immediately. No further strobes are issued, and a partially written word pair is acceptable.
- `start` sampled high at edge k puts RD_R in cycle k+1.
- Each word takes 7 cycles. The pass takes (ROWS-1)·WORDS_PER_ROW·7 cycles, then one DONE cycle.
- `busy` falls in the cycle after DONE. A `start` in that cycle (IDLE) is accepted.

## Configuration
- `SAND_SKIP_EMPTY_EN` defined:
  - In LATCH, if `region`==32'h0, go straight to NEXT with no CALC, WR_R or WR_F.
  - An empty word takes 4 cycles.
  - `docalculations` is not pulsed for that word.
- `SAND_SKIP_EMPTY_EN` undefined: every word takes the full 7-cycle sequence.

## Test plan
- ROWS=3, WORDS_PER_ROW=2, RAM all 0, macro off. Pulse `start` → addresses visited in order:
  - region 2, floor 4
  - region 3, floor 5
  - region 0, floor 2
  - region 1, floor 3
  
  `done` exactly 28 cycles after RD_R first occurs; RAM unchanged with a pass-through `sand_update` model.
- Same grid, `sand_update` model that swaps `region` and `floor`, word 2 = 32'hC000_0003 → word 4 = 32'hC000_0003 and word 2 = 0 after the pass.
- Check edge flags per word: `screenbegin` high only for col 0 and `screenend` high only for col 1, throughout RD_R..NEXT.
- `start` re-pulsed mid-pass → ignored. `start` in the first IDLE cycle after DONE → second pass begins next cycle.
- Drop `reset_n` during WR_R → outputs 0 asynchronously; no `mem_we` after release until a new `start`.
- `SAND_SKIP_EMPTY_EN` defined, ROWS=3, WORDS_PER_ROW=2, all zero → pass length 16 cycles, `docalculations` never high.

Source files
------------

// File: rtl/sand_row_fetch.sv
// sand_row_fetch: frame-level sequencer for the falling-sand simulation.
// Walks the packed grid bottom-up one 32-bit word at a time. For each word
// it reads the region and floor words, hands them to sand_update, and writes
// both results back.
// Optional feature macro: SAND_SKIP_EMPTY_EN. When it is defined, an all-empty
// region word skips the evaluate/write-back phases.
module sand_row_fetch #(
    parameter int WORDS_PER_ROW = 40,
    parameter int ROWS          = 480,
    parameter int ADDR_W        = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       region,
    output logic [31:0]       floor,
    output logic              docalculations,
    output logic              screenbegin,
    output logic              screenend,
    input  logic [31:0]       new_region,
    input  logic [31:0]       new_floor
);

    localparam int ROW_W = (ROWS > 2) ? $clog2(ROWS) : 1;
    localparam int COL_W = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;

    localparam logic [ROW_W-1:0]  ROW_FIRST  = ROW_W'(ROWS - 2);
    localparam logic [COL_W-1:0]  COL_LAST   = COL_W'(WORDS_PER_ROW - 1);
    localparam logic [ADDR_W-1:0] BASE_FIRST = ADDR_W'((ROWS - 2) * WORDS_PER_ROW);
    localparam logic [ADDR_W-1:0] ROW_STEP   = ADDR_W'(WORDS_PER_ROW);

    typedef enum logic [3:0] {
        IDLE,
        RD_R,
        RD_F,
        LATCH,
        CALC,
        WR_R,
        WR_F,
        NEXT,
        DONE
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [ROW_W-1:0]  row;
    logic [ROW_W-1:0]  row_nx;
    logic [COL_W-1:0]  col;
    logic [COL_W-1:0]  col_nx;
    logic [ADDR_W-1:0] row_base;
    logic [ADDR_W-1:0] base_nx;
    logic [ADDR_W-1:0] region_addr_nx;
    logic [ADDR_W-1:0] floor_addr_nx;
    logic              scan_nx;
    // The region result goes straight into the mem_wdata register on entry to
    // WR_R; only the floor result needs its own holding register.
    logic [31:0]       wr_floor;

    // Next-state and next-position decode. Outputs are registered from these
    // so every strobe lines up with the state it belongs to.
    always_comb begin
        state_nx = state;
        row_nx   = row;
        col_nx   = col;
        base_nx  = row_base;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = RD_R;
                    row_nx   = ROW_FIRST;
                    col_nx   = '0;
                    base_nx  = BASE_FIRST;
                end
            end
            RD_R:  state_nx = RD_F;
            RD_F:  state_nx = LATCH;
            LATCH: begin
`ifdef SAND_SKIP_EMPTY_EN
                if (region == 32'h0) begin
                    state_nx = NEXT;
                end else begin
                    state_nx = CALC;
                end
`else
                state_nx = CALC;
`endif
            end
            CALC:  state_nx = WR_R;
            WR_R:  state_nx = WR_F;
            WR_F:  state_nx = NEXT;
            NEXT: begin
                if (col != COL_LAST) begin
                    col_nx   = col + 1'b1;
                    state_nx = RD_R;
                end else begin
                    col_nx = '0;
                    if (row == '0) begin
                        state_nx = DONE;
                    end else begin
                        row_nx   = row - 1'b1;
                        base_nx  = row_base - ROW_STEP;
                        state_nx = RD_R;
                    end
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Addresses for the upcoming cycle; the floor word sits one row below.
    always_comb begin
        region_addr_nx = base_nx + ADDR_W'(col_nx);
        floor_addr_nx  = region_addr_nx + ROW_STEP;
        scan_nx        = (state_nx inside {RD_R, RD_F, LATCH, CALC, WR_R, WR_F, NEXT});
    end

    // Sequencer state, data latches and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            row            <= '0;
            col            <= '0;
            row_base       <= '0;
            region         <= '0;
            floor          <= '0;
            wr_floor       <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            mem_addr       <= '0;
            mem_re         <= 1'b0;
            mem_we         <= 1'b0;
            mem_wdata      <= '0;
            docalculations <= 1'b0;
            screenbegin    <= 1'b0;
            screenend      <= 1'b0;
        end else begin
            state    <= state_nx;
            row      <= row_nx;
            col      <= col_nx;
            row_base <= base_nx;

            if (state == RD_F) begin
                region <= mem_rdata;
            end
            if (state == LATCH) begin
                floor <= mem_rdata;
            end
            if (state == CALC) begin
                wr_floor <= new_floor;
            end

            busy           <= (state_nx != IDLE);
            done           <= (state_nx == DONE);
            mem_re         <= (state_nx == RD_R) || (state_nx == RD_F);
            mem_we         <= (state_nx == WR_R) || (state_nx == WR_F);
            docalculations <= (state_nx == CALC);
            screenbegin    <= scan_nx && (col_nx == '0);
            screenend      <= scan_nx && (col_nx == COL_LAST);

            case (state_nx)
                RD_R:    mem_addr <= region_addr_nx;
                WR_R:    mem_addr <= region_addr_nx;
                RD_F:    mem_addr <= floor_addr_nx;
                WR_F:    mem_addr <= floor_addr_nx;
                default: mem_addr <= '0;
            endcase

            case (state_nx)
                WR_R:    mem_wdata <= new_region;
                WR_F:    mem_wdata <= wr_floor;
                default: mem_wdata <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_sand_row_fetch.sv
// tb_sand_row_fetch: directed bench for sand_row_fetch on a 3x2-word grid.
// Uses a 1-cycle-latency RAM model and a sand_update stand-in that either
// passes words through or swaps region and floor.
module tb_sand_row_fetch;

    localparam int WPR  = 2;
    localparam int NROW = 3;
    localparam int AW   = 4;
`ifdef SAND_SKIP_EMPTY_EN
    localparam int WC   = 4;
`else
    localparam int WC   = 7;
`endif
    localparam int PASS = (NROW - 1) * WPR * WC;

    logic          clk;
    logic          reset_n;
    logic          start;
    logic          busy;
    logic          done;
    logic [AW-1:0] mem_addr;
    logic          mem_re;
    logic          mem_we;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
    logic [31:0]   region;
    logic [31:0]   floor;
    logic          docalculations;
    logic          screenbegin;
    logic          screenend;
    logic [31:0]   new_region;
    logic [31:0]   new_floor;

    logic [31:0]   ram [0:15];
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [31:0]   load_data;
    logic          swap;

    int checks;
    int errors;
    int regionAddr [4] = '{2, 3, 0, 1};

    sand_row_fetch #(
        .WORDS_PER_ROW(WPR),
        .ROWS(NROW),
        .ADDR_W(AW)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .start(start),
        .busy(busy),
        .done(done),
        .mem_addr(mem_addr),
        .mem_re(mem_re),
        .mem_we(mem_we),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .region(region),
        .floor(floor),
        .docalculations(docalculations),
        .screenbegin(screenbegin),
        .screenend(screenend),
        .new_region(new_region),
        .new_floor(new_floor)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // sand_update stand-in: pass-through or region/floor swap.
    assign new_region = swap ? floor : region;
    assign new_floor  = swap ? region : floor;

    // Grid RAM with 1-cycle read latency and a bench preload port.
    always @(posedge clk) begin
        if (load_en) begin
            ram[load_addr] <= load_data;
        end else if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
        if (mem_re) begin
            mem_rdata <= ram[mem_addr];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    task automatic loadWord(input logic [AW-1:0] a, input logic [31:0] d);
        @(negedge clk);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        @(negedge clk);
        load_en   = 1'b0;
    endtask

    // Pulse start for one edge; returns at the negedge of the first RD_R cycle.
    task automatic applyStimulus();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Cycle-by-cycle check of an all-empty pass; entered in the first RD_R
    // cycle, returns in the DONE cycle.
    task automatic checkPass(input bit midStart);
        for (int t = 0; t < PASS; t++) begin
            int w;
            int p;
            logic [31:0] ea;
            w  = t / WC;
            p  = t % WC;
            ea = 32'h0;
            if (p == 0 || (WC == 7 && p == 4)) ea = regionAddr[w];
            if (p == 1 || (WC == 7 && p == 5)) ea = regionAddr[w] + WPR;
            checkOutput($sformatf("re t=%0d", t), mem_re, (p < 2));
            checkOutput($sformatf("we t=%0d", t), mem_we, (WC == 7 && (p == 4 || p == 5)));
            checkOutput($sformatf("addr t=%0d", t), mem_addr, ea);
            checkOutput($sformatf("calc t=%0d", t), docalculations, (WC == 7 && p == 3));
            checkOutput($sformatf("sbegin t=%0d", t), screenbegin, (w % 2 == 0));
            checkOutput($sformatf("send t=%0d", t), screenend, (w % 2 == 1));
            checkOutput($sformatf("busy t=%0d", t), busy, 1'b1);
            checkOutput($sformatf("done t=%0d", t), done, 1'b0);
            start = (midStart && t == 10);
            @(negedge clk);
        end
        start = 1'b0;
        checkOutput("done pulse", done, 1'b1);
        checkOutput("busy in done", busy, 1'b1);
        checkOutput("re in done", mem_re, 1'b0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " busy"}, busy, 1'b0);
        checkOutput({tag, " done"}, done, 1'b0);
        checkOutput({tag, " addr"}, mem_addr, 32'h0);
        checkOutput({tag, " re"}, mem_re, 1'b0);
        checkOutput({tag, " we"}, mem_we, 1'b0);
        checkOutput({tag, " wdata"}, mem_wdata, 32'h0);
        checkOutput({tag, " region"}, region, 32'h0);
        checkOutput({tag, " floor"}, floor, 32'h0);
        checkOutput({tag, " calc"}, docalculations, 1'b0);
        checkOutput({tag, " sbegin"}, screenbegin, 1'b0);
        checkOutput({tag, " send"}, screenend, 1'b0);
    endtask

    initial begin
        bit found;
        checks    = 0;
        errors    = 0;
        reset_n   = 1'b0;
        start     = 1'b0;
        swap      = 1'b0;
        load_en   = 1'b0;
        load_addr = '0;
        load_data = '0;

        // Reset state.
        #12;
        checkAllZero("reset");
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) loadWord(AW'(i), 32'h0);

        // Empty pass with a stray mid-pass start, then a back-to-back pass.
        $display("[TB] empty pass");
        applyStimulus();
        checkPass(1'b1);
        @(negedge clk);
        checkOutput("idle busy", busy, 1'b0);
        checkOutput("idle done", done, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("b2b re", mem_re, 1'b1);
        checkOutput("b2b addr", mem_addr, 32'd2);
        checkPass(1'b0);
        @(negedge clk);
        for (int i = 0; i < 6; i++) checkOutput($sformatf("ram%0d clean", i), ram[i], 32'h0);

        // Swap model moves the grain in word 2 down into word 4.
        $display("[TB] swap pass");
        loadWord(AW'(2), 32'hC000_0003);
        swap = 1'b1;
        applyStimulus();
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (done) found = 1'b1;
            else @(negedge clk);
        end
        checkOutput("swap done seen", found, 1'b1);
        @(negedge clk);
        checkOutput("swap ram4", ram[4], 32'hC000_0003);
        checkOutput("swap ram2", ram[2], 32'h0);
        checkOutput("swap ram0", ram[0], 32'h0);
        checkOutput("swap ram5", ram[5], 32'h0);

        // Reset asserted during WR_R aborts the pass.
        $display("[TB] reset abort");
        swap = 1'b0;
        loadWord(AW'(2), 32'h0000_0001);
        applyStimulus();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (mem_we) found = 1'b1;
            else @(negedge clk);
        end
        checkOutput("wr_r seen", found, 1'b1);
        checkOutput("wr_r addr", mem_addr, 32'd2);
        reset_n = 1'b0;
        #1;
        checkAllZero("abort");
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checkOutput($sformatf("post we c=%0d", i), mem_we, 1'b0);
            checkOutput($sformatf("post busy c=%0d", i), busy, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
